// File: rtl/add_serial_if.sv
// add_serial_if: operand request, result handshake and flag bundle for add_serial.
interface add_serial_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ctrl;
  logic             Sign;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Add_result;
  logic             Carry;
  logic             Zero;
  logic             Overflow;
  logic             Negative;
  logic             busy;
  modport master (
    output in_valid, A, B, ctrl, Sign, out_ready,
    input  in_ready, out_valid, Add_result, Carry, Zero, Overflow, Negative, busy
  );
  modport slave (
    input  in_valid, A, B, ctrl, Sign, out_ready,
    output in_ready, out_valid, Add_result, Carry, Zero, Overflow, Negative, busy
  );
endinterface

// File: rtl/add_serial.sv
// add_serial: chunk-serial add/subtract with flags; ADD_SERIAL_STICKY_OVF_EN adds a sticky overflow bit.
module add_serial #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         reset,
  add_serial_if.slave  bus
`ifdef ADD_SERIAL_STICKY_OVF_EN
  ,
  input  logic         sticky_clr,
  output logic         sticky_ovf
`endif
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             carry_q, carry_d, sign_q, sign_d, ctrl_q, ctrl_d;
  logic             cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d, neg_q, neg_d;
  logic [CHUNK:0]   sum;
  logic             last, hs;
  assign sum  = {1'b0, a_q[cnt_q*CHUNK +: CHUNK]} + {1'b0, b_q[cnt_q*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
  assign last = cnt_q == CW'(N - 1);
  assign hs   = state_q == DONE && bus.out_ready;
  assign bus.in_ready   = state_q == IDLE;
  assign bus.busy       = state_q != IDLE;
  assign bus.out_valid  = state_q == DONE;
  assign bus.Add_result = res_q;
  assign bus.Carry      = cout_q;
  assign bus.Zero       = zero_q;
  assign bus.Overflow   = ovf_q;
  assign bus.Negative   = neg_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    sign_d  = sign_q;
    ctrl_d  = ctrl_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        a_d     = bus.A;
        b_d     = bus.ctrl ? ~bus.B : bus.B;
        carry_d = bus.ctrl;
        sign_d  = bus.Sign;
        ctrl_d  = bus.ctrl;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        res_d[cnt_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        carry_d = sum[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        // flags only latch once the full result exists, so they never show partial values
        if (last) begin
          state_d = DONE;
          cout_d  = sum[CHUNK];
          zero_d  = res_d == '0;
          ovf_d   = sign_q & (a_q[WIDTH-1] == b_q[WIDTH-1]) & (res_d[WIDTH-1] != a_q[WIDTH-1]);
          neg_d   = sign_q ? res_d[WIDTH-1] ^ ovf_d : ctrl_q & ~sum[CHUNK];
        end
      end
      default: state_d = hs ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sign_q  <= 1'b0;
      ctrl_q  <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sign_q  <= sign_d;
      ctrl_q  <= ctrl_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
    end
  end
`ifdef ADD_SERIAL_STICKY_OVF_EN
  logic sticky_q;
  assign sticky_ovf = sticky_q;
  always_ff @(posedge clk) begin
    if (reset) sticky_q <= 1'b0;
    else       sticky_q <= (hs & ovf_q) | (sticky_q & ~sticky_clr);
  end
`endif
endmodule

// File: tb/tb_add_serial.sv
// tb_add_serial: scoreboard bench for add_serial at 32/8 plus a 16/16 single-cycle instance.
module tb_add_serial;
  typedef struct packed {
    logic [31:0] r;
    logic        c, z, o, n;
  } exp_t;
  logic clk, reset;
  logic sticky_clr;
  logic sticky_ovf, sticky_ovf16;
  int   n_vec, n_err;
  exp_t sb[$];
  exp_t last_e;
  add_serial_if #(.WIDTH(32)) bus ();
  add_serial_if #(.WIDTH(16)) bus16 ();
  add_serial #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
`ifdef ADD_SERIAL_STICKY_OVF_EN
    , .sticky_clr(sticky_clr), .sticky_ovf(sticky_ovf)
`endif
  );
  add_serial #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16)
`ifdef ADD_SERIAL_STICKY_OVF_EN
    , .sticky_clr(1'b0), .sticky_ovf(sticky_ovf16)
`endif
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  // reference from exact integer arithmetic rather than the carry-chain formulas
  function automatic exp_t model(input logic [31:0] a, b, input logic c, s);
    exp_t e;
    logic signed [33:0] ex;
    logic [32:0] us;
    ex  = c ? $signed({{2{a[31]}}, a}) - $signed({{2{b[31]}}, b})
            : $signed({{2{a[31]}}, a}) + $signed({{2{b[31]}}, b});
    us  = {1'b0, a} + {1'b0, b};
    e.r = c ? a - b : a + b;
    e.c = c ? (a >= b) : us[32];
    e.z = e.r == 32'd0;
    e.o = s & (ex > 34'sd2147483647 || ex < -34'sd2147483648);
    e.n = s ? ex < 0 : c & (a < b);
    return e;
  endfunction
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic accept(input logic [31:0] a, b, input logic c, s);
    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.ctrl = c;
    bus.Sign = s;
    sb.push_back(model(a, b, c, s));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    bus.ctrl = ~c;
    bus.Sign = ~s;
  endtask
  task automatic wait_result();
    int lat;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      check("busy_run", bus.busy, 1);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 4);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL scoreboard: observed empty expected entry");
    end else begin
      last_e = sb.pop_front();
      check("result", bus.Add_result, last_e.r);
      check("carry", bus.Carry, last_e.c);
      check("zero", bus.Zero, last_e.z);
      check("overflow", bus.Overflow, last_e.o);
      check("negative", bus.Negative, last_e.n);
    end
  endtask
  task automatic handoff(input logic clr);
    bus.out_ready = 1'b1;
    sticky_clr = clr;
    @(negedge clk);
    bus.out_ready = 1'b0;
    sticky_clr = 1'b0;
    check("out_valid_after_handoff", bus.out_valid, 0);
    check("in_ready_after_handoff", bus.in_ready, 1);
  endtask
  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    sticky_clr = 1'b0;
    bus.in_valid = 1'b0;  bus.A = '0;  bus.B = '0;  bus.ctrl = 1'b0;  bus.Sign = 1'b0;  bus.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.A = '0; bus16.B = '0; bus16.ctrl = 1'b0; bus16.Sign = 1'b0; bus16.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_result", {bus.Add_result, bus.Carry, bus.Zero, bus.Overflow, bus.Negative}, 0);
    reset = 1'b0;
    accept(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
    wait_result();
    check("ovf_case_result", bus.Add_result, 32'h8000_0000);
    check("ovf_case_flags", {bus.Carry, bus.Zero, bus.Overflow, bus.Negative}, 4'b0010);
    handoff(1'b0);
`ifdef ADD_SERIAL_STICKY_OVF_EN
    check("sticky_set", sticky_ovf, 1);
`endif
    accept(32'd5, 32'd5, 1'b1, 1'b1);
    wait_result();
    check("zero_case_flags", {bus.Add_result, bus.Carry, bus.Zero, bus.Overflow, bus.Negative}, {32'd0, 4'b1100});
    handoff(1'b0);
`ifdef ADD_SERIAL_STICKY_OVF_EN
    check("sticky_held", sticky_ovf, 1);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    check("sticky_cleared", sticky_ovf, 0);
`endif
    accept(32'd3, 32'd5, 1'b1, 1'b0);
    wait_result();
    check("borrow_case", {bus.Add_result, bus.Carry, bus.Overflow, bus.Negative}, {32'hFFFF_FFFE, 3'b001});
    // hold the result while a new request is offered; it must be ignored
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.A = 32'h1234_5678;
      bus.B = 32'h0;
      @(negedge clk);
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_result", {bus.Add_result, bus.Carry, bus.Zero, bus.Overflow, bus.Negative},
            {last_e.r, last_e.c, last_e.z, last_e.o, last_e.n});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    check("hold_release_idle", {bus.in_ready, bus.busy, bus.out_valid}, 3'b100);
    accept(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    check("mid_reset_outputs", {bus.Add_result, bus.Carry, bus.Zero, bus.Overflow, bus.Negative, bus.busy}, 0);
    check("mid_reset_in_ready", bus.in_ready, 1);
    begin
      logic seen;
      seen = 1'b0;
      repeat (6) begin
        @(negedge clk);
        seen |= bus.out_valid;
      end
      check("no_valid_after_reset", seen, 0);
    end
    for (int i = 0; i < 6; i++) begin
      accept($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_result();
      handoff(1'b0);
    end
    accept(32'h8000_0000, 32'h1, 1'b1, 1'b1);
    wait_result();
    handoff(1'b0);
`ifdef ADD_SERIAL_STICKY_OVF_EN
    check("sticky_reset_cleared", sticky_ovf, 1);
    accept(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1);
    wait_result();
    handoff(1'b1);
    check("sticky_set_wins", sticky_ovf, 1);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    check("sticky_clr_again", sticky_ovf, 0);
`endif
    @(negedge clk);
    bus16.in_valid = 1'b1;
    bus16.A = 16'h7FFF;
    bus16.B = 16'h0001;
    bus16.ctrl = 1'b0;
    bus16.Sign = 1'b1;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    check("w16_not_yet", bus16.out_valid, 0);
    @(negedge clk);
    check("w16_latency1", bus16.out_valid, 1);
    check("w16_result", {bus16.Add_result, bus16.Carry, bus16.Zero, bus16.Overflow, bus16.Negative},
          {16'h8000, 4'b0010});
    bus16.out_ready = 1'b1;
    @(negedge clk);
    bus16.out_ready = 1'b0;
    check("w16_idle", {bus16.in_ready, bus16.out_valid}, 2'b10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
